// File: rtl/tivi_pkg.sv
// Shared definitions for the tivi video blocks: stream reader FSM states and RAM read timing.
package tivi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rsr_state_t;

    // Cycles from ram_addr to valid ram_dout on the tivi block RAM read port.
    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/ram_stream_fifo.sv
// Synchronous FIFO buffering RAM read data for the stream reader; DEPTH must be a power of two.
module ram_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    // A pop frees the slot a same-cycle push needs, so push at full is fine when popping.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // NOTE: storage is left out of reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for the tivi block RAM: streams LENGTH words from BASE onward on a valid/ready port.
// Define RAM_STREAM_READER_ABORT_EN to add the abort input that cancels a running burst.
module ram_stream_reader
    import tivi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT = RAM_READ_LATENCY;

    rsr_state_t            r_state;
    rsr_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [LAT-1:0]        r_inflight;

    logic                  w_abort;
    logic                  w_start_ok;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_credit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drained;
    logic [CW:0]           w_occupancy;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign w_abort = abort && ((r_state == FETCH) || (r_state == DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = r_inflight[LAT-1] && !w_abort;

    // Every in-flight read owns a FIFO slot, so RAM data can always be captured.
    assign w_occupancy = {1'b0, w_fifo_count} + (CW+1)'($countones(r_inflight)) + (CW+1)'(1);
    assign w_credit    = !(w_fifo_full && !w_pop) &&
                         (w_occupancy <= (CW+1)'(FIFO_DEPTH) + (CW+1)'(w_pop));

    assign w_issue      = (r_state == FETCH) && w_credit && !w_abort;
    assign w_last_issue = w_issue && (r_remaining == (ADDR_WIDTH+1)'(1));
    assign w_drained    = (r_inflight == '0) &&
                          (w_fifo_empty || ((w_fifo_count == CW'(1)) && w_pop));

    assign busy      = (r_state != IDLE) || w_start_ok;
    assign done      = (r_state == DONE);
    assign ram_addr  = r_addr;
    assign out_valid = !w_fifo_empty;

    always_comb begin
        // NOTE: the default comes first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (length == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (w_abort) begin
                    w_state_next = DONE;
                end else if (w_last_issue) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_abort || w_drained) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            if (w_start_ok && (length != '0)) begin
                r_addr      <= base;
                r_remaining <= length;
            end else if (w_issue) begin
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                if (!w_last_issue) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat_one
            always_ff @(posedge clk) begin
                if (!rst_n || w_abort) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= w_issue;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk) begin
                if (!rst_n || w_abort) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= {r_inflight[LAT-2:0], w_issue};
                end
            end
        end
    endgenerate

    ram_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_data  (ram_dout),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

endmodule
